// File: rtl/time_set_ctrl.sv
// Time-setting controller: freezes the time counter, lets the user edit hour/minute/second
// with mode/inc/dec pulses, and loads the edited value back or aborts on inactivity.
module time_set_ctrl #(
  parameter logic [24:0] BLINK_MAX   = 25'd24_999_999,
  parameter logic [28:0] TIMEOUT_MAX = 29'd499_999_999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [7:0] cur_h,
  input  logic [7:0] cur_m,
  input  logic [7:0] cur_s,
  output logic       run_en,
  output logic       load,
  output logic [7:0] load_h,
  output logic [7:0] load_m,
  output logic [7:0] load_s,
  output logic [1:0] sel,
  output logic       blink
);

  typedef enum logic [2:0] {StRun, StSetH, StSetM, StSetS, StCommit} state_e;

  state_e      r_state, w_state_next;
  logic        r_run_en, r_load, r_blink;
  logic [1:0]  r_sel, w_sel_next;
  logic [7:0]  r_load_h, r_load_m, r_load_s;
  logic [7:0]  r_edit_h, r_edit_m, r_edit_s;
  logic [24:0] r_blink_cnt;
  logic [28:0] r_to_cnt;
  logic        w_in_set, w_next_set, w_any_key, w_timeout, w_adj;

  // Out-of-range captured values snap to 0 on inc and to the field maximum on dec.
  function automatic logic [7:0] f_step(input logic [7:0] v, input logic [7:0] vmax,
                                        input logic up);
    if (up) return (v >= vmax) ? 8'd0 : v + 8'd1;
    else    return (v == 8'd0 || v > vmax) ? vmax : v - 8'd1;
  endfunction

  always_comb begin
    w_in_set   = (r_state == StSetH) || (r_state == StSetM) || (r_state == StSetS);
    w_any_key  = key_mode | key_inc | key_dec;
    w_timeout  = w_in_set && (r_to_cnt == TIMEOUT_MAX);
    w_adj      = w_in_set && !key_mode && !w_timeout && (key_inc ^ key_dec);
    w_state_next = r_state;
    unique case (r_state)
      StRun:    if (key_mode) w_state_next = StSetH;
      StSetH:   if (w_timeout) w_state_next = StRun; else if (key_mode) w_state_next = StSetM;
      StSetM:   if (w_timeout) w_state_next = StRun; else if (key_mode) w_state_next = StSetS;
      StSetS:   if (w_timeout) w_state_next = StRun; else if (key_mode) w_state_next = StCommit;
      StCommit: w_state_next = StRun;
      default:  w_state_next = StRun;
    endcase
    w_next_set = (w_state_next == StSetH) || (w_state_next == StSetM) ||
                 (w_state_next == StSetS);
    w_sel_next = 2'd0;
    unique case (w_state_next)
      StSetH:  w_sel_next = 2'd1;
      StSetM:  w_sel_next = 2'd2;
      StSetS:  w_sel_next = 2'd3;
      default: w_sel_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StRun;
      r_run_en    <= 1'b1;
      r_load      <= 1'b0;
      r_sel       <= 2'd0;
      r_blink     <= 1'b1;
      r_load_h    <= 8'd0;
      r_load_m    <= 8'd0;
      r_load_s    <= 8'd0;
      r_edit_h    <= 8'd0;
      r_edit_m    <= 8'd0;
      r_edit_s    <= 8'd0;
      r_blink_cnt <= 25'd0;
      r_to_cnt    <= 29'd0;
    end else begin
      r_state  <= w_state_next;
      r_run_en <= (w_state_next == StRun);
      r_load   <= (w_state_next == StCommit);
      r_sel    <= w_sel_next;
      if (w_state_next == StCommit) begin
        r_load_h <= r_edit_h;
        r_load_m <= r_edit_m;
        r_load_s <= r_edit_s;
      end

      if (r_state == StRun && key_mode) begin
        r_edit_h <= cur_h;
        r_edit_m <= cur_m;
        r_edit_s <= cur_s;
      end else if (w_adj) begin
        unique case (r_state)
          StSetH:  r_edit_h <= f_step(r_edit_h, 8'd23, key_inc);
          StSetM:  r_edit_m <= f_step(r_edit_m, 8'd59, key_inc);
          StSetS:  r_edit_s <= f_step(r_edit_s, 8'd59, key_inc);
          default: ;
        endcase
      end

      // Both counters only run while staying idle inside an edit session.
      if (w_in_set && w_next_set && !w_any_key) begin
        r_to_cnt <= r_to_cnt + 29'd1;
        if (r_blink_cnt == BLINK_MAX) begin
          r_blink_cnt <= 25'd0;
          r_blink     <= ~r_blink;
        end else begin
          r_blink_cnt <= r_blink_cnt + 25'd1;
        end
      end else begin
        r_to_cnt    <= 29'd0;
        r_blink_cnt <= 25'd0;
        r_blink     <= 1'b1;
      end
    end
  end

  assign run_en = r_run_en;
  assign load   = r_load;
  assign load_h = r_load_h;
  assign load_m = r_load_m;
  assign load_s = r_load_s;
  assign sel    = r_sel;
  assign blink  = r_blink;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter BLINK_MAX, default 25'd24_999_999; cycle count minus one between blink toggles (0.5 s at 50 MHz).
REQ-002 Parameter TIMEOUT_MAX, default 29'd499_999_999; idle cycles minus one before an edit session aborts (10 s at 50 MHz).
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_mode  input  1  single-cycle pulse that advances the edit field.
REQ-006 key_inc  input  1  single-cycle pulse that increments the selected field.
REQ-007 key_dec  input  1  single-cycle pulse that decrements the selected field.
REQ-008 cur_h / cur_m / cur_s  input  8 each  live hour/minute/second values from the time counter.
REQ-009 run_en  output  1  1 = time counter may advance; 0 = counter frozen.
REQ-010 load  output  1  single-cycle strobe; counter takes load_h/m/s and clears its sub-second count.
REQ-011 load_h / load_m / load_s  output  8 each  edited values, valid while load=1.
REQ-012 sel  output  2  field being edited: 0 none, 1 hour, 2 minute, 3 second.
REQ-013 blink  output  1  display enable for the selected field; 1 = show.

Function
REQ-014 States: RUN, SET_H, SET_M, SET_S, COMMIT; all outputs registered.
REQ-015 RUN: run_en=1, sel=0, blink=1, load=0; key_mode -> SET_H and capture cur_h/m/s into edit_h/m/s on the same edge.
REQ-016 SET_H, SET_M, SET_S: run_en=0; sel=1, 2, 3 respectively.
REQ-017 key_mode transitions: SET_H -> SET_M, SET_M -> SET_S, SET_S -> COMMIT.
REQ-018 COMMIT lasts exactly 1 cycle: load=1, load_h/m/s = edit_h/m/s, run_en=0; next state RUN.
REQ-019 The first RUN cycle after COMMIT has run_en=1 and load=0; load_h/m/s hold their last values.
REQ-020 key_inc on the selected field: hour 23->0, minute/second 59->0, otherwise +1.
REQ-021 key_dec on the selected field: 0->23 (hour) or 0->59 (minute/second), otherwise -1.
REQ-022 Captured out-of-range value (hour>23, min/sec>59): inc yields 0, dec yields the field maximum.
REQ-023 Simultaneous key_inc and key_dec: no change to the value.
REQ-024 key_mode together with key_inc/key_dec: mode is honoured, inc/dec ignored.
REQ-025 key_inc/key_dec are ignored in RUN and COMMIT; key_mode is ignored in COMMIT.
REQ-026 Blink counter runs only in SET states; on reaching BLINK_MAX it wraps to 0 and blink toggles.
REQ-027 Any accepted key in a SET state clears the blink counter and forces blink=1.
REQ-028 Entering SET_H from RUN also clears the blink counter and forces blink=1.
REQ-029 Timeout counter clears on entry to SET_H and on any key pulse in a SET state; otherwise it increments.
REQ-030 Timeout counter at TIMEOUT_MAX: next state RUN, no load, edits discarded, run_en=1, sel=0, blink=1.
REQ-031 Timeout counter is 29 bits and does not count in RUN.
REQ-032 Timeout and key_mode in the same cycle: the timeout wins.

Reset
REQ-033 rst_n low, asynchronously and in any state including mid-edit: state=RUN, run_en=1, load=0, sel=0, blink=1, load_h/m/s=0.
REQ-034 The same reset clears edit_h/m/s, the blink counter and the timeout counter; no load is issued on reset exit.

Verification (BLINK_MAX=3, TIMEOUT_MAX=20)
REQ-035 cur=12:34:56; mode; inc x2; mode; dec; mode; mode -> exactly one load pulse with load_h/m/s=14/33/56; run_en=1 the cycle after.
REQ-036 cur_h=23, enter SET_H, inc -> edit 0; cur_m=0, SET_M, dec -> edit 59; cur_h=30, SET_H, dec -> 23.
REQ-037 Enter SET_M, no keys for 21 cycles -> RUN, run_en=1, sel=0, load never asserted.
REQ-038 In SET_H: inc+dec same cycle -> value unchanged; mode+inc same cycle -> sel=2, hour unchanged.
REQ-039 Idle in SET_S: blink toggles every 4 cycles; an inc pulse forces blink=1 on the next cycle.
REQ-040 rst_n low during SET_M after edits -> immediate RUN outputs, no load; a fresh session captures the new cur values.
